eth_frame_mem_tx: RTL and testbench

Transmit-side counterpart of the frame detector path. Replays a frame image stored in a byte-wide pattern memory onto an AXI4-Stream master towards a TEMAC. Supports a configurable frame count, a configurable inter-frame gap and clean abort. It sits in the same clock domain as the TEMAC TX interface and reads memory through a synchronous read port of the pattern memory.

---
 rtl/eth_frame_mem_tx.sv | 205 ++++++++++++++++++++
 tb/tb_eth_frame_mem_tx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_mem_tx.sv
// Replays a frame image from a synchronous-read byte memory onto an AXI4-Stream master.
// Optional zero padding up to C_MIN_FRAME is enabled by defining ETH_FRAME_TX_PAD_EN.
module eth_frame_mem_tx #(
  parameter int C_ADDR_WIDTH = 11,
  parameter int C_MIN_FRAME  = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [C_ADDR_WIDTH-1:0] frame_len,
  input  logic [15:0]             repeat_count,
  input  logic [15:0]             gap_cycles,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             frames_sent,
  output logic [C_ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]              mem_rdata,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);
  localparam int AW = C_ADDR_WIDTH;
`ifdef ETH_FRAME_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam logic [AW-1:0] MIN_LEN = AW'(C_MIN_FRAME);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;
  state_t state_reg, state_next;

  logic [AW-1:0] len_reg, total_reg, fetch_idx_reg, mem_addr_reg;
  logic [15:0]   rep_reg, gap_reg, gap_cnt_reg, sent_cnt_reg;
  logic [31:0]   frames_sent_reg;
  logic          inflight_reg, inflight_last_reg, inflight_pad_reg;
  logic          abort_reg, done_reg;
  logic [7:0]    fifo_data_reg [2];
  logic          fifo_last_reg [2];
  logic          rd_ptr_reg, wr_ptr_reg;
  logic [1:0]    count_reg;

  logic          tvalid, pop, frame_end, issue;
  logic          accept, go_idle, restart, gap_load, set_abort, count_frame;
  logic [2:0]    occ_after_pop;
  logic [AW-1:0] fetch_next;

  assign tvalid        = (count_reg != 2'd0);
  assign pop           = tvalid && m_axis_tready;
  assign frame_end     = pop && (fifo_last_reg[rd_ptr_reg] || abort_reg);
  assign fetch_next    = fetch_idx_reg + 1'b1;
  // Reads are issued only when the skid buffer is guaranteed a free slot when the data lands.
  assign occ_after_pop = {1'b0, count_reg} + {2'b0, inflight_reg} - {2'b0, pop};
  assign issue         = ((state_reg == FETCH) || (state_reg == SEND)) &&
                         (fetch_idx_reg < total_reg) && (occ_after_pop < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    go_idle     = 1'b0;
    restart     = 1'b0;
    gap_load    = 1'b0;
    set_abort   = 1'b0;
    count_frame = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (frame_len == '0) go_idle = 1'b1;
          else                 state_next = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          go_idle    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (frame_end) begin
          if (abort_reg) begin
            go_idle    = 1'b1;
            state_next = IDLE;
          end else begin
            count_frame = 1'b1;
            if ((rep_reg != 16'd0) && (sent_cnt_reg + 16'd1 == rep_reg)) begin
              go_idle    = 1'b1;
              state_next = IDLE;
            end else if (gap_reg == 16'd0) begin
              restart    = 1'b1;
              state_next = FETCH;
            end else begin
              gap_load   = 1'b1;
              state_next = GAP;
            end
          end
        end else if (abort) begin
          set_abort = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          go_idle    = 1'b1;
          state_next = IDLE;
        end else if (gap_cnt_reg == 16'd1) begin
          restart    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg           <= '0;
      total_reg         <= '0;
      fetch_idx_reg     <= '0;
      mem_addr_reg      <= '0;
      rep_reg           <= '0;
      gap_reg           <= '0;
      gap_cnt_reg       <= '0;
      sent_cnt_reg      <= '0;
      frames_sent_reg   <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      inflight_pad_reg  <= 1'b0;
      abort_reg         <= 1'b0;
      done_reg          <= 1'b0;
      fifo_data_reg[0]  <= '0;
      fifo_data_reg[1]  <= '0;
      fifo_last_reg[0]  <= 1'b0;
      fifo_last_reg[1]  <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      count_reg         <= '0;
    end else begin
      done_reg <= go_idle;
      if (accept) begin
        len_reg         <= frame_len;
        total_reg       <= (PAD_EN && (frame_len < MIN_LEN)) ? MIN_LEN : frame_len;
        rep_reg         <= repeat_count;
        gap_reg         <= gap_cycles;
        frames_sent_reg <= '0;
        sent_cnt_reg    <= '0;
        abort_reg       <= 1'b0;
        mem_addr_reg    <= '0;
        fetch_idx_reg   <= '0;
      end
      if (restart) begin
        mem_addr_reg  <= '0;
        fetch_idx_reg <= '0;
      end
      if (issue) begin
        fetch_idx_reg     <= fetch_next;
        if (fetch_next < len_reg) mem_addr_reg <= fetch_next;
        inflight_last_reg <= (fetch_idx_reg == total_reg - 1'b1);
        inflight_pad_reg  <= PAD_EN && (fetch_idx_reg >= len_reg);
      end
      if (gap_load)              gap_cnt_reg <= gap_reg;
      else if (state_reg == GAP) gap_cnt_reg <= gap_cnt_reg - 16'd1;
      if (set_abort) abort_reg <= 1'b1;
      if (count_frame) begin
        frames_sent_reg <= frames_sent_reg + 32'd1;
        sent_cnt_reg    <= sent_cnt_reg + 16'd1;
      end
      if (go_idle) begin
        // Drop anything still buffered or in flight from the abandoned frame.
        inflight_reg <= 1'b0;
        abort_reg    <= 1'b0;
        count_reg    <= '0;
        rd_ptr_reg   <= 1'b0;
        wr_ptr_reg   <= 1'b0;
      end else begin
        inflight_reg <= issue;
        if (inflight_reg) begin
          fifo_data_reg[wr_ptr_reg] <= inflight_pad_reg ? 8'h00 : mem_rdata;
          fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
          wr_ptr_reg                <= ~wr_ptr_reg;
        end
        if (pop) rd_ptr_reg <= ~rd_ptr_reg;
        count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
      end
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign frames_sent   = frames_sent_reg;
  assign mem_addr      = mem_addr_reg;
  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = fifo_data_reg[rd_ptr_reg];
  assign m_axis_tlast  = tvalid && (fifo_last_reg[rd_ptr_reg] || abort_reg);
  assign m_axis_tuser  = tvalid && abort_reg;
endmodule

// File: tb/tb_eth_frame_mem_tx.sv
// Scoreboard bench for eth_frame_mem_tx: expected beats are queued at start and
// compared on every AXIS handshake; protocol and timing checks run each cycle.
module tb_eth_frame_mem_tx;
  localparam int AW   = 11;
  localparam int MINF = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [AW-1:0] frame_len = '0;
  logic [15:0]   repeat_count = '0, gap_cycles = '0;
  logic          busy, done;
  logic [31:0]   frames_sent;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tuser, m_axis_tlast, m_axis_tvalid;
  logic          m_axis_tready = 1'b1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  eth_frame_mem_tx #(.C_ADDR_WIDTH(AW), .C_MIN_FRAME(MINF)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
    .repeat_count(repeat_count), .gap_cycles(gap_cycles), .busy(busy), .done(done),
    .frames_sent(frames_sent), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;
  beat_t exp_q[$];
  int    gaps[$];

  int cyc = 0, hs_count = 0, done_count = 0, tlast_cyc = 0, done_cyc = 0, gap_len = 0;
  bit in_frame = 0, between = 0, prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last, prev_user;

  // One clock cycle: monitor on the falling edge, return just after the rising edge.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (rst) begin
      in_frame = 0; between = 0; prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
            m_axis_tlast !== prev_last || m_axis_tuser !== prev_user) begin
          errors++;
          $display("FAIL axis_stable cyc=%0d: got v=%b d=%h l=%b u=%b, required v=1 d=%h l=%b u=%b",
                   cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, prev_data, prev_last, prev_user);
        end
      end
      if (in_frame) begin
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL no_bubble cyc=%0d: got tvalid=%b, required 1", cyc, m_axis_tvalid);
        end
      end
      if (between && m_axis_tvalid === 1'b1) begin
        gaps.push_back(gap_len);
        between = 0;
      end else if (between) begin
        gap_len++;
      end
      if (done === 1'b1) begin
        done_count++; done_cyc = cyc; between = 0;
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected cyc=%0d: got d=%h l=%b u=%b, required no beat",
                   cyc, m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tlast !== e.l || m_axis_tuser !== e.u) begin
            errors++;
            $display("FAIL beat cyc=%0d: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                     cyc, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
          end
        end
        if (m_axis_tlast === 1'b1) begin
          in_frame = 0; between = 1; gap_len = 0; tlast_cyc = cyc;
        end else begin
          in_frame = 1;
        end
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      prev_user  = m_axis_tuser;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void push_frame(input int len, input int flag_idx);
    int    n;
    beat_t b;
    n = len;
`ifdef ETH_FRAME_TX_PAD_EN
    if (len > 0 && len < MINF) n = MINF;
`endif
    for (int i = 0; i < n; i++) begin
      if (flag_idx >= 0 && i > flag_idx) break;
      b.d = (i < len) ? mem[i] : 8'h00;
      b.l = (i == n - 1) || (i == flag_idx);
      b.u = (i == flag_idx);
      exp_q.push_back(b);
    end
  endfunction

  // Leaves the bench just after the edge that sampled start.
  task automatic pulse_start(input int len, input int rep, input int gap);
    frame_len    = AW'(len);
    repeat_count = 16'(rep);
    gap_cycles   = 16'(gap);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles, input bit rnd, input string name);
    int  d0;
    bit  seen;
    d0   = done_count;
    seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      if (done_count > d0) begin
        seen = 1;
        break;
      end
    end
    m_axis_tready = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, required done", name, max_cycles);
    end
  endtask

  task automatic check_leftover(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_beats: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 ||
        m_axis_tdata !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        mem_addr !== '0 || frames_sent !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%b l=%b u=%b d=%h busy=%b done=%b addr=%0d fs=%0d, required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, done, mem_addr, frames_sent);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    push_frame(64, -1);
    pulse_start(64, 1, 0);
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_s0: got tvalid=%b busy=%b, required tvalid=0 busy=1", m_axis_tvalid, busy);
    end
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_s1: got tvalid=%b, required 0", m_axis_tvalid);
    end
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency_s2: got tvalid=%b, required 1", m_axis_tvalid);
    end
    run_until_done(200, 0, "single");
    check_leftover("single");
    checks++;
    if (done_cyc != tlast_cyc + 1) begin
      errors++;
      $display("FAIL single_done_timing: got done %0d cycles after tlast, required 1", done_cyc - tlast_cyc);
    end
    checks++;
    if (frames_sent !== 32'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_status: got frames_sent=%0d busy=%b, required 1 and 0", frames_sent, busy);
    end
  endtask

  task automatic test_repeat_gap();
    int d0;
    d0 = done_count;
    gaps.delete();
    for (int f = 0; f < 3; f++) push_frame(16, -1);
    pulse_start(16, 3, 10);
    run_until_done(400, 0, "repeat");
    check_leftover("repeat");
    checks++;
    if (gaps.size() != 2) begin
      errors++;
      $display("FAIL repeat_gap_count: got %0d gaps, required 2", gaps.size());
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] != 12) begin
        errors++;
        $display("FAIL repeat_gap_len: got %0d idle cycles, required 12", gaps[i]);
      end
    end
    tick(); tick();
    checks++;
    if (frames_sent !== 32'd3 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL repeat_status: got frames_sent=%0d dones=%0d, required 3 and 1", frames_sent, done_count - d0);
    end
  endtask

  task automatic test_backpressure();
    push_frame(100, -1);
    pulse_start(100, 1, 0);
    run_until_done(2000, 1, "bp");
    check_leftover("bp");
    checks++;
    if (frames_sent !== 32'd1) begin
      errors++;
      $display("FAIL bp_frames_sent: got %0d, required 1", frames_sent);
    end
  endtask

  task automatic test_abort();
    int  target;
    bit  hit;
    gaps.delete();
    for (int f = 0; f < 3; f++) push_frame(64, -1);
    push_frame(64, 41);
    target = hs_count + 3 * 64 + 40;
    pulse_start(64, 0, 5);
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      if (hs_count == target) begin
        hit = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach_beat40: got %0d beats, required %0d", hs_count, target);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_until_done(50, 0, "abort");
    check_leftover("abort");
    checks++;
    if (frames_sent !== 32'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_status: got frames_sent=%0d busy=%b, required 3 and 0", frames_sent, busy);
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] != 7) begin
        errors++;
        $display("FAIL abort_gap_len: got %0d idle cycles, required 7", gaps[i]);
      end
    end
  endtask

  task automatic test_padding();
    int h0;
    h0 = hs_count;
    push_frame(20, -1);
    pulse_start(20, 1, 0);
    run_until_done(200, 0, "pad");
    check_leftover("pad");
    checks++;
`ifdef ETH_FRAME_TX_PAD_EN
    if (hs_count - h0 != MINF) begin
      errors++;
      $display("FAIL pad_beats: got %0d beats, required %0d", hs_count - h0, MINF);
    end
`else
    if (hs_count - h0 != 20) begin
      errors++;
      $display("FAIL pad_beats: got %0d beats, required 20", hs_count - h0);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    int  target, h0;
    bit  hit;
    push_frame(16, -1);
    push_frame(16, -1);
    target = hs_count + 16 + 10;
    pulse_start(16, 2, 0);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (hs_count >= target) begin
        hit = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!hit || frames_sent !== 32'd1 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got beats=%0d fs=%0d tvalid=%b, required beats>=%0d fs=1 tvalid=1",
               hs_count, frames_sent, m_axis_tvalid, target);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 ||
        m_axis_tdata !== 8'h00 || busy !== 1'b0 || mem_addr !== '0 || frames_sent !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b l=%b u=%b d=%h busy=%b addr=%0d fs=%0d, required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, mem_addr, frames_sent);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    h0 = hs_count;
    pulse_start(0, 1, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: got done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (hs_count != h0 || frames_sent !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_idle: got beats=%0d fs=%0d done=%b, required 0 beats fs=0 done=0",
               hs_count - h0, frames_sent, done);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
    test_reset();
    test_single_frame();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 37 + 5);
    test_repeat_gap();
    test_backpressure();
    test_abort();
    test_padding();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
